// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data memory: round-robin grants, bounded M1 lock,
// and a read-tag pipeline that steers each read result back to its issuing master.
module dmem_arbiter #(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_wr,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_lock,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_BACKOFF  = 2'd2
  } state_e;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_e;

  state_e            state_q, state_d;
  master_e           last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RD_LAT-1:0] rd_own_q, rd_own_d;
  logic [DW-1:0]     m0_rdata_q, m0_rdata_d;
  logic [DW-1:0]     m1_rdata_q, m1_rdata_d;
  logic              rr_g0, rr_g1;

  // Round-robin pick: on a tie the master that was not granted last wins
  always_comb begin
    rr_g0 = 1'b0;
    rr_g1 = 1'b0;
    if (m0_req && m1_req) begin
      rr_g0 = (last_gnt_q == M1);
      rr_g1 = (last_gnt_q == M0);
    end else begin
      rr_g0 = m0_req;
      rr_g1 = m1_req;
    end
  end

  // Grant selection and lock FSM next state
  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_LOCKED: begin
        if (m1_lock) begin
          m1_gnt     = m1_req;
          lock_cnt_d = lock_cnt_q + CNT_W'(1);
          if (lock_cnt_d >= CNT_W'(LOCK_MAX)) begin
            state_d = ST_BACKOFF;
          end
        end else begin
          // Lock dropped: this cycle is already arbitrated round-robin
          m0_gnt     = rr_g0;
          m1_gnt     = rr_g1;
          lock_cnt_d = '0;
          state_d    = ST_UNLOCKED;
        end
      end
      ST_BACKOFF: begin
        m0_gnt     = m0_req;
        lock_cnt_d = '0;
        state_d    = ST_UNLOCKED;
      end
      default: begin
        m0_gnt     = rr_g0;
        m1_gnt     = rr_g1;
        lock_cnt_d = '0;
        if (rr_g1 && m1_lock) begin
          lock_cnt_d = CNT_W'(1);
          state_d    = (LOCK_MAX <= 1) ? ST_BACKOFF : ST_LOCKED;
        end
      end
    endcase

    // Backoff leaves M1 marked as last so M0 also keeps the following tie
    if (state_q == ST_BACKOFF) begin
      last_gnt_d = M1;
    end else if (m0_gnt) begin
      last_gnt_d = M0;
    end else if (m1_gnt) begin
      last_gnt_d = M1;
    end
  end

  // Memory strobes follow the granted master in the same cycle
  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (m0_gnt) begin
      mem_rd    = !m0_wr;
      mem_wr    = m0_wr;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (m1_gnt) begin
      mem_rd    = !m1_wr;
      mem_wr    = m1_wr;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  // Read tag shift register: valid + owner, RD_LAT stages deep
  if (RD_LAT > 1) begin : g_pipe_multi
    always_comb begin
      rd_vld_d = {rd_vld_q[RD_LAT-2:0], mem_rd};
      rd_own_d = {rd_own_q[RD_LAT-2:0], m1_gnt};
    end
  end else begin : g_pipe_single
    always_comb begin
      rd_vld_d = mem_rd;
      rd_own_d = m1_gnt;
    end
  end

  // Steer returning data; the idle master keeps presenting its last result
  always_comb begin
    m0_rvalid  = rd_vld_q[RD_LAT-1] && !rd_own_q[RD_LAT-1];
    m1_rvalid  = rd_vld_q[RD_LAT-1] && rd_own_q[RD_LAT-1];
    m0_rdata   = m0_rvalid ? mem_rdata : m0_rdata_q;
    m1_rdata   = m1_rvalid ? mem_rdata : m1_rdata_q;
    m0_rdata_d = m0_rdata;
    m1_rdata_d = m1_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_UNLOCKED;
      last_gnt_q <= M1;
      lock_cnt_q <= '0;
      rd_vld_q   <= '0;
      rd_own_q   <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rd_vld_q   <= rd_vld_d;
      rd_own_q   <= rd_own_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
    end
  end

endmodule
